// File: rtl/lsu_mem_port_if.sv
// Bundle of the pipeline request/response handshake and the data-memory bus
// seen by the load/store port. The slave modport is the load/store port itself;
// the master modport is the environment (MEM stage plus data memory).
interface lsu_mem_port_if #(
  parameter int ADDR_W = 13
);
  // Pipeline request channel
  logic              req_valid;
  logic              req_ready;
  logic              req_store;
  logic [2:0]        req_funct3;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;

  // Pipeline response channel
  logic              resp_valid;
  logic              resp_ready;
  logic [31:0]       resp_rdata;
  logic              resp_err;

  // Data-memory bus
  logic              mem_write;
  logic [2:0]        mem_funct3;
  logic [31:0]       mem_din;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_dout;

  modport slave (
    input  req_valid, req_store, req_funct3, req_addr, req_wdata,
    input  resp_ready,
    input  mem_dout,
    output req_ready,
    output resp_valid, resp_rdata, resp_err,
    output mem_write, mem_funct3, mem_din, mem_addr
  );

  modport master (
    output req_valid, req_store, req_funct3, req_addr, req_wdata,
    output resp_ready,
    output mem_dout,
    input  req_ready,
    input  resp_valid, resp_rdata, resp_err,
    input  mem_write, mem_funct3, mem_din, mem_addr
  );
endinterface

// File: rtl/lsu_mem_port.sv
// Load/store initiator for the main data memory. Takes one request at a time,
// rejects misaligned / out-of-range / illegal-funct3 accesses without touching
// memory, issues a single write strobe for stores, and returns extended load
// data. Sequence: IDLE -> ACCESS -> [LDATA ->] RESP -> IDLE, or IDLE -> RESP on
// a fault. The memory returns read data the cycle after it samples mem_addr.
module lsu_mem_port #(
  parameter int ADDR_W      = 13,
  parameter bit CHECK_RANGE = 1'b1
) (
  input logic           clk,
  input logic           reset,   // asynchronous, active-low
  lsu_mem_port_if.slave bus
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_LDATA  = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  logic [1:0]  state;
  logic        is_store;       // latched request kind, steers ACCESS exit
  logic        funct3_legal;
  logic        misaligned;
  logic        out_of_range;
  logic        fault;
  logic        accept;
  logic [31:0] wdata_sized;
  logic [31:0] din_lane;
  logic [31:0] rd_lane;
  logic [31:0] load_ext;

  assign bus.req_ready = (state == S_IDLE);
  assign accept        = (state == S_IDLE) && bus.req_valid;
  assign fault         = !funct3_legal || misaligned || out_of_range;

  // Classify the incoming request: legal funct3 for its kind, natural alignment
  // and, optionally, whether it addresses beyond the memory.
  // NOTE: every output of a combinational block gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    funct3_legal = 1'b0;
    misaligned   = 1'b0;
    out_of_range = 1'b0;
    if (bus.req_store) begin
      funct3_legal = (bus.req_funct3 == F3_B) || (bus.req_funct3 == F3_H) ||
                     (bus.req_funct3 == F3_W);
    end else begin
      funct3_legal = (bus.req_funct3 == F3_B)  || (bus.req_funct3 == F3_H)  ||
                     (bus.req_funct3 == F3_W)  || (bus.req_funct3 == F3_BU) ||
                     (bus.req_funct3 == F3_HU);
    end
    case (bus.req_funct3[1:0])
      2'b01:   misaligned = bus.req_addr[0];
      2'b10:   misaligned = (bus.req_addr[1:0] != 2'b00);
      default: misaligned = 1'b0;
    endcase
    if (CHECK_RANGE) begin
      out_of_range = ((bus.req_addr >> ADDR_W) != 32'd0);
    end
  end

  // Store data: trim to the access size, then move into its byte lane.
  always_comb begin
    wdata_sized = bus.req_wdata;
    case (bus.req_funct3[1:0])
      2'b00:   wdata_sized = {24'd0, bus.req_wdata[7:0]};
      2'b01:   wdata_sized = {16'd0, bus.req_wdata[15:0]};
      default: wdata_sized = bus.req_wdata;
    endcase
    din_lane = wdata_sized << {bus.req_addr[1:0], 3'b000};
  end

  // Load data: bring the addressed lane down to bit 0 and extend by funct3.
  // mem_addr and mem_funct3 still hold the accepted request during LDATA.
  always_comb begin
    rd_lane  = bus.mem_dout >> {bus.mem_addr[1:0], 3'b000};
    load_ext = 32'd0;
    case (bus.mem_funct3)
      F3_B:    load_ext = {{24{rd_lane[7]}}, rd_lane[7:0]};
      F3_H:    load_ext = {{16{rd_lane[15]}}, rd_lane[15:0]};
      F3_W:    load_ext = rd_lane;
      F3_BU:   load_ext = {24'd0, rd_lane[7:0]};
      F3_HU:   load_ext = {16'd0, rd_lane[15:0]};
      default: load_ext = 32'd0;
    endcase
  end

  // Sequencer: one request in flight, faults skip straight to the response.
  // NOTE: all clocked state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      is_store <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.req_valid) begin
            is_store <= bus.req_store;
            state    <= fault ? S_RESP : S_ACCESS;
          end
        end
        S_ACCESS: state <= is_store ? S_RESP : S_LDATA;
        S_LDATA:  state <= S_RESP;
        S_RESP: begin
          if (bus.resp_ready) begin
            state <= S_IDLE;
          end
        end
        default:  state <= S_IDLE;
      endcase
    end
  end

  // Memory bus flops: loaded only on a legal accept and held until the next
  // one, so the memory's bank select stays put through ACCESS and LDATA. The
  // write strobe is high only for the ACCESS cycle after a store accept, and
  // the asynchronous reset drops it immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.mem_write  <= 1'b0;
      bus.mem_funct3 <= 3'd0;
      bus.mem_din    <= 32'd0;
      bus.mem_addr   <= '0;
    end else begin
      bus.mem_write <= accept && !fault && bus.req_store;
      if (accept && !fault) begin
        bus.mem_addr   <= bus.req_addr[ADDR_W-1:0];
        bus.mem_funct3 <= bus.req_funct3;
        if (bus.req_store) begin
          bus.mem_din <= din_lane;
        end
      end
    end
  end

  // Response flops: set on entry to RESP, held while the consumer stalls,
  // cleared on the handshake.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.resp_valid <= 1'b0;
      bus.resp_err   <= 1'b0;
      bus.resp_rdata <= 32'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept && fault) begin
            bus.resp_valid <= 1'b1;
            bus.resp_err   <= 1'b1;
            bus.resp_rdata <= 32'd0;
          end
        end
        S_ACCESS: begin
          if (is_store) begin
            bus.resp_valid <= 1'b1;
            bus.resp_err   <= 1'b0;
            bus.resp_rdata <= 32'd0;
          end
        end
        S_LDATA: begin
          bus.resp_valid <= 1'b1;
          bus.resp_err   <= 1'b0;
          bus.resp_rdata <= load_ext;
        end
        S_RESP: begin
          if (bus.resp_ready) begin
            bus.resp_valid <= 1'b0;
            bus.resp_err   <= 1'b0;
            bus.resp_rdata <= 32'd0;
          end
        end
        default: begin
          bus.resp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_port.sv
// Randomised scoreboard bench for lsu_mem_port. Requests are scored against a
// byte-array reference memory at issue time; a monitor process checks every
// memory write, address hold, response value, error flag and latency.
module tb_lsu_mem_port;

  localparam int ADDR_W = 13;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  lsu_mem_port_if #(.ADDR_W(ADDR_W)) bus ();

  lsu_mem_port #(.ADDR_W(ADDR_W), .CHECK_RANGE(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic        legal;
    logic        wr;
    logic [12:0] addr;
    logic [31:0] din;
    logic [2:0]  f3;
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          drive_cyc;
  } exp_t;

  exp_t        sb_q[$];
  int          n_tests    = 0;
  int          n_fail     = 0;
  int          cyc        = 0;
  int          rr_mode    = 0;   // 0 random, 1 hold low, 2 hold high
  bit          monitor_en = 1'b0;
  logic [7:0]  ref_mem [8192];
  logic [31:0] env_mem [2048] = '{default: 32'h0};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Data memory environment: byte-lane writes, read data one cycle after address.
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] din,
                                        input logic [2:0] f3, input logic [1:0] lo);
    logic [31:0] w;
    int nb;
    w  = old;
    nb = 1 << f3[1:0];
    for (int j = 0; j < 4; j++)
      if (j >= int'(lo) && j < int'(lo) + nb) w[8*j +: 8] = din[8*j +: 8];
    return w;
  endfunction

  always @(posedge clk) begin
    bus.mem_dout <= env_mem[bus.mem_addr[12:2]];
    if (bus.mem_write)
      env_mem[bus.mem_addr[12:2]] <= merge(env_mem[bus.mem_addr[12:2]], bus.mem_din,
                                           bus.mem_funct3, bus.mem_addr[1:0]);
  end

  // Reference: RV32 load/store semantics over a flat byte array.
  function automatic exp_t model(input logic st, input logic [2:0] f3,
                                 input logic [31:0] a, input logic [31:0] wd);
    exp_t e;
    int nb;
    logic ok;
    logic [31:0] mask, v;
    nb   = 1 << f3[1:0];
    ok   = st ? (f3 <= 3'd2)
              : (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    if (ok && (a % nb) != 0) ok = 1'b0;
    if (a >= 32'h2000) ok = 1'b0;
    mask    = (nb >= 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * nb)) - 32'h1);
    e.legal = ok;
    e.err   = !ok;
    e.addr  = a[12:0];
    e.f3    = f3;
    e.rdata = 32'h0;
    e.wr    = 1'b0;
    e.din   = 32'h0;
    e.drive_cyc = 0;
    if (!ok) begin
      e.lat = 1;
    end else if (st) begin
      e.lat = 2;
      e.wr  = 1'b1;
      e.din = (wd & mask) << (8 * (a % 4));
      for (int i = 0; i < nb; i++) ref_mem[a + i] = wd[8*i +: 8];
    end else begin
      e.lat = 3;
      v = 32'h0;
      for (int i = 0; i < nb; i++) v = v | ({24'h0, ref_mem[a + i]} << (8 * i));
      if (!f3[2] && nb < 4 && v[8*nb - 1]) v = v | ~mask;
      e.rdata = v;
    end
    return e;
  endfunction

  // Issue one request; while the port is busy, throw junk at it to show req_* is ignored.
  task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd);
    exp_t e;
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.req_ready && n < 200) begin
      bus.req_valid  = 1'($urandom_range(0, 1));
      bus.req_store  = 1'($urandom_range(0, 1));
      bus.req_funct3 = 3'($urandom_range(0, 7));
      bus.req_addr   = $urandom;
      bus.req_wdata  = $urandom;
      n++;
      @(negedge clk);
    end
    if (!bus.req_ready) begin
      check("req_ready_timeout", bus.req_ready, 1);
      bus.req_valid = 1'b0;
      return;
    end
    bus.req_valid  = 1'b1;
    bus.req_store  = st;
    bus.req_funct3 = f3;
    bus.req_addr   = a;
    bus.req_wdata  = wd;
    e = model(st, f3, a, wd);
    e.drive_cyc = cyc;
    sb_q.push_back(e);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
  endtask

  // Consumer ready: random, or pinned low/high for the stall scenario.
  initial begin
    bus.resp_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rr_mode)
        1:       bus.resp_ready = 1'b0;
        2:       bus.resp_ready = 1'b1;
        default: bus.resp_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Monitor: checks writes, address hold and responses against the queue head.
  initial begin
    bit resp_seen;
    int wr_cnt;
    resp_seen = 1'b0;
    wr_cnt    = 0;
    forever begin
      @(negedge clk);
      if (monitor_en && reset) begin
        if (sb_q.size() > 0 && sb_q[0].legal && !resp_seen && cyc > sb_q[0].drive_cyc)
          check("mem_addr_hold", 32'(bus.mem_addr), 32'(sb_q[0].addr));
        if (bus.mem_write) begin
          if (sb_q.size() == 0 || !sb_q[0].wr) begin
            check("unexpected_write", 32'(bus.mem_write), 0);
          end else begin
            wr_cnt++;
            check("wr_addr",   32'(bus.mem_addr),   32'(sb_q[0].addr));
            check("wr_din",    bus.mem_din,         sb_q[0].din);
            check("wr_funct3", 32'(bus.mem_funct3), 32'(sb_q[0].f3));
          end
        end
        if (bus.resp_valid && !resp_seen) begin
          if (sb_q.size() == 0) begin
            check("resp_without_req", 32'(bus.resp_valid), 0);
          end else begin
            check("resp_rdata",  bus.resp_rdata,            sb_q[0].rdata);
            check("resp_err",    32'(bus.resp_err),         32'(sb_q[0].err));
            check("latency",     32'(cyc - sb_q[0].drive_cyc), 32'(sb_q[0].lat));
            check("write_count", 32'(wr_cnt),               sb_q[0].wr ? 32'd1 : 32'd0);
            check("ready_in_resp", 32'(bus.req_ready),      0);
            resp_seen = 1'b1;
          end
        end
        if (bus.resp_valid && bus.resp_ready && resp_seen) begin
          void'(sb_q.pop_front());
          resp_seen = 1'b0;
          wr_cnt    = 0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] cap;
    int n;
    logic [31:0] a, base;
    logic [2:0] f3;
    logic st;
    logic [2:0] legal_f3 [5];
    legal_f3[0] = 3'd0; legal_f3[1] = 3'd1; legal_f3[2] = 3'd2;
    legal_f3[3] = 3'd4; legal_f3[4] = 3'd5;
    for (int i = 0; i < 8192; i++) ref_mem[i] = 8'h00;

    bus.req_valid  = 1'b0;
    bus.req_store  = 1'b0;
    bus.req_funct3 = 3'd0;
    bus.req_addr   = 32'd0;
    bus.req_wdata  = 32'd0;
    reset          = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_req_ready",  32'(bus.req_ready),  1);
    check("rst_resp_valid", 32'(bus.resp_valid), 0);
    check("rst_resp_err",   32'(bus.resp_err),   0);
    check("rst_resp_rdata", bus.resp_rdata,      0);
    check("rst_mem_write",  32'(bus.mem_write),  0);
    check("rst_mem_funct3", 32'(bus.mem_funct3), 0);
    check("rst_mem_din",    bus.mem_din,         0);
    check("rst_mem_addr",   32'(bus.mem_addr),   0);
    reset = 1'b1;

    // Reset asserted while a store is in ACCESS
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_store  = 1'b1;
    bus.req_funct3 = 3'd2;
    bus.req_addr   = 32'h100;
    bus.req_wdata  = 32'h1234_5678;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    check("abort_write_before", 32'(bus.mem_write), 1);
    check("abort_ready_busy",   32'(bus.req_ready), 0);
    #2 reset = 1'b0;
    #1;
    check("abort_write_drop", 32'(bus.mem_write),  0);
    check("abort_resp_valid", 32'(bus.resp_valid), 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("abort_no_resp", 32'(bus.resp_valid), 0);
    end
    check("abort_ready_after", 32'(bus.req_ready), 1);
    check("abort_no_mem_write", env_mem[32'h100 >> 2], 32'h0);

    monitor_en = 1'b1;

    // Directed cases
    issue(1'b1, 3'd2, 32'h0000_1004, 32'hDEAD_BEEF);   // SW
    issue(1'b1, 3'd0, 32'h0000_0803, 32'h0000_00A5);   // SB into top lane
    issue(1'b0, 3'd0, 32'h0000_0803, 32'h0);           // LB  -> FFFFFFA5
    issue(1'b0, 3'd4, 32'h0000_0803, 32'h0);           // LBU -> 000000A5
    issue(1'b1, 3'd2, 32'h0000_0000, 32'h8001_0000);
    issue(1'b0, 3'd1, 32'h0000_0002, 32'h0);           // LH  -> FFFF8001
    issue(1'b0, 3'd5, 32'h0000_0002, 32'h0);           // LHU -> 00008001
    issue(1'b0, 3'd2, 32'h0000_0006, 32'h0);           // misaligned word
    issue(1'b0, 3'd1, 32'h0000_0001, 32'h0);           // misaligned half
    issue(1'b1, 3'd2, 32'h0000_2000, 32'h1111_1111);   // out of range
    issue(1'b0, 3'd3, 32'h0000_0010, 32'h0);           // illegal funct3
    issue(1'b1, 3'd4, 32'h0000_0010, 32'h0);           // SBU is not a store
    issue(1'b1, 3'd0, 32'h0000_1FFF, 32'h0000_007E);   // last byte
    issue(1'b0, 3'd0, 32'h0000_1FFF, 32'h0);
    issue(1'b0, 3'd0, 32'h0000_2000, 32'h0);           // one past the end

    // Response stalled for 5 cycles
    rr_mode = 1;
    issue(1'b0, 3'd2, 32'h0000_1004, 32'h0);
    n = 0;
    while (!bus.resp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("stall_valid_seen", 32'(bus.resp_valid), 1);
    cap = bus.resp_rdata;
    repeat (5) begin
      @(negedge clk);
      check("stall_hold_valid", 32'(bus.resp_valid), 1);
      check("stall_hold_rdata", bus.resp_rdata,      cap);
      check("stall_ready_low",  32'(bus.req_ready),  0);
    end
    rr_mode = 2;
    @(posedge clk);
    @(posedge clk);
    #2;
    check("post_hs_ready", 32'(bus.req_ready),  1);
    check("post_hs_valid", 32'(bus.resp_valid), 0);
    rr_mode = 0;

    // Randomised traffic concentrated on a few windows so loads hit stored data
    for (int t = 0; t < 250; t++) begin
      case ($urandom_range(0, 3))
        0:       base = 32'h0000;
        1:       base = 32'h0800;
        2:       base = 32'h1000;
        default: base = 32'h1FE0;
      endcase
      case ($urandom_range(0, 9))
        0:       a = $urandom;
        1:       a = 32'h1FFC + 32'($urandom_range(0, 7));
        default: a = base + 32'($urandom_range(0, 31));
      endcase
      if ($urandom_range(0, 9) < 8) f3 = legal_f3[$urandom_range(0, 4)];
      else                          f3 = 3'($urandom_range(0, 7));
      st = 1'($urandom_range(0, 1));
      if (!st && $urandom_range(0, 1) == 1) a = {a[31:2], 2'b00} & ~(32'((1 << f3[1:0]) - 1));
      issue(st, f3, a, $urandom);
    end

    n = 0;
    while (sb_q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("drain", 32'(sb_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
